// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op/state enums and lane helpers for the MEM-stage data memory controller
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'b0000,
        OP_SB   = 4'b0001,
        OP_SH   = 4'b0010,
        OP_SW   = 4'b0011,
        OP_LB   = 4'b1000,
        OP_LH   = 4'b1001,
        OP_LW   = 4'b1010,
        OP_LBU  = 4'b1100,
        OP_LHU  = 4'b1101
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } dmc_state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return |lo;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_SB:   return 4'b0001 << lo;
            OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   return {4{wd[7:0]}};
            OP_SH:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] lane_extend(input logic [3:0] op, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            default: return rd;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-enable, store replication and load extension
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    assign be_o    = lane_be(op_i, addr_lo_i);
    assign wdata_o = lane_wdata(op_i, wdata_i);
    assign load_o  = lane_extend(op_i, addr_lo_i, rdata_i);

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage req/ack data memory controller; MISALIGN_TRAP_EN enables misalign faults
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        read_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busywait,
    output logic [31:0]       load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              misalign_flt
);

    dmc_state_e  state_q, state_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] load_ext;
    logic        op_load, op_store, op_valid, op_misalign;
    logic        req_d, busy_d;

    assign op_load  = op_is_load(read_write);
    assign op_store = op_is_store(read_write);
    assign op_valid = op_load | op_store;

`ifdef MISALIGN_TRAP_EN
    logic flt_q, flt_d;

    assign op_misalign = op_is_misaligned(read_write, addr[1:0]);
    assign flt_d       = (state_q == ST_IDLE) && op_valid && op_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flt_q <= 1'b0;
        else          flt_q <= flt_d;
    end

    assign misalign_flt = reset_n && (state_q == ST_DONE) && flt_q;
`else
    assign op_misalign  = 1'b0;
    assign misalign_flt = 1'b0;
`endif

    mem_lane_align u_lane (
        .op_i      (read_write),
        .addr_lo_i (addr[1:0]),
        .wdata_i   (wdata),
        .rdata_i   (mem_rdata),
        .be_o      (mem_be),
        .wdata_o   (mem_wdata),
        .load_o    (load_ext)
    );

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    busy_d = 1'b1;
                    if (op_misalign) begin
                        state_d = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        state_d = mem_ack ? ST_DONE : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                req_d  = 1'b1;
                if (mem_ack) state_d = ST_DONE;
            end
            // DONE lets EX/MEM advance; the op still visible this cycle is not reissued
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_data_d = (req_d && mem_ack && op_load) ? load_ext : load_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
        end
    end

    // Reset gates the handshake outputs so they fall while reset_n is still low
    assign busywait  = reset_n & busy_d;
    assign mem_req   = reset_n & req_d;
    assign mem_we    = reset_n & req_d & op_store;
    assign mem_addr  = addr[ADDR_W-1:2];
    assign load_data = load_data_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

    localparam logic [3:0] RW_NONE = 4'b0000;
    localparam logic [3:0] RW_LB   = 4'b1000;
    localparam logic [3:0] RW_LH   = 4'b1001;
    localparam logic [3:0] RW_LW   = 4'b1010;
    localparam logic [3:0] RW_LBU  = 4'b1100;
    localparam logic [3:0] RW_LHU  = 4'b1101;
    localparam logic [3:0] RW_SB   = 4'b0001;
    localparam logic [3:0] RW_SH   = 4'b0010;
    localparam logic [3:0] RW_SW   = 4'b0011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  read_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busywait;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        misalign_flt;

    int n_checks = 0;
    int n_errors = 0;
    int req_cycles = 0;

    logic        snap_req, snap_we;
    logic [29:0] snap_addr;
    logic [3:0]  snap_be;
    logic [31:0] snap_wdata;
    logic        unstable;
    int          busy_n;
    int          req_base;

    data_mem_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read_write   (read_write),
        .addr         (addr),
        .wdata        (wdata),
        .busywait     (busywait),
        .load_data    (load_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .misalign_flt (misalign_flt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req) req_cycles++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, acks after ack_delay busy cycles (negative = never), returns in the first non-busy cycle
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_delay);
        read_write = op;
        addr       = a;
        wdata      = wd;
        mem_rdata  = rd;
        busy_n     = 0;
        unstable   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            mem_ack = (c == ack_delay);
            #1;
            if (c == 0) begin
                snap_req   = mem_req;
                snap_we    = mem_we;
                snap_addr  = mem_addr;
                snap_be    = mem_be;
                snap_wdata = mem_wdata;
            end else if (busywait && (mem_req !== snap_req || mem_we !== snap_we ||
                         mem_addr !== snap_addr || mem_be !== snap_be || mem_wdata !== snap_wdata)) begin
                unstable = 1'b1;
            end
            if (!busywait) break;
            busy_n++;
            tick();
        end
        mem_ack = 1'b0;
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        read_write = RW_NONE;
        addr       = 32'h0;
        wdata      = 32'h0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;
        #12;
        check("rst_busywait", busywait, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_misalign", misalign_flt, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        run_op(RW_LW, 32'h100, 32'h0, 32'h12345678, 3);
        check("lw_busy_cycles", busy_n, 4);
        check("lw_req", snap_req, 1'b1);
        check("lw_we", snap_we, 1'b0);
        check("lw_addr", snap_addr, 32'h40);
        check("lw_be", snap_be, 4'hF);
        check("lw_wait_stable", unstable, 1'b0);
        check("lw_done_req", mem_req, 1'b0);
        check("lw_load_data", load_data, 32'h12345678);
        tick();

        run_op(RW_LB, 32'h103, 32'h0, 32'h80112233, 0);
        check("lb_busy_cycles", busy_n, 1);
        check("lb_load_data", load_data, 32'hFFFFFF80);
        tick();
        run_op(RW_LBU, 32'h103, 32'h0, 32'h80112233, 0);
        check("lbu_load_data", load_data, 32'h00000080);
        tick();
        run_op(RW_LH, 32'h102, 32'h0, 32'h80017FFF, 1);
        check("lh_load_data", load_data, 32'hFFFF8001);
        tick();
        run_op(RW_LHU, 32'h100, 32'h0, 32'h8001F00D, 0);
        check("lhu_load_data", load_data, 32'h0000F00D);
        tick();

        run_op(RW_SB, 32'h102, 32'h000000AB, 32'hDEADBEEF, 1);
        check("sb_be", snap_be, 4'b0100);
        check("sb_wdata", snap_wdata, 32'hABABABAB);
        check("sb_we", snap_we, 1'b1);
        check("sb_busy_cycles", busy_n, 2);
        check("sb_load_unchanged", load_data, 32'h0000F00D);
        tick();
        run_op(RW_SH, 32'h102, 32'h00001234, 32'h0, 0);
        check("sh_be", snap_be, 4'b1100);
        check("sh_wdata", snap_wdata, 32'h12341234);
        tick();

        req_base = req_cycles;
        run_op(RW_LW, 32'h200, 32'h0, 32'hCAFEF00D, 0);
        check("b2b_lw_busy", busy_n, 1);
        tick();
        run_op(RW_SW, 32'h204, 32'h55AA55AA, 32'h0, 0);
        check("b2b_sw_busy", busy_n, 1);
        check("b2b_sw_be", snap_be, 4'hF);
        check("b2b_sw_wdata", snap_wdata, 32'h55AA55AA);
        check("b2b_sw_addr", snap_addr, 32'h81);
        tick();
        read_write = RW_NONE;
        tick();
        tick();
        check("b2b_req_count", req_cycles - req_base, 2);
        check("b2b_load_data", load_data, 32'hCAFEF00D);

        mem_rdata = 32'h77777777;
        mem_ack   = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        check("idle_ack_ignored", load_data, 32'hCAFEF00D);
        check("idle_ack_busy", busywait, 1'b0);

        read_write = RW_LW;
        addr       = 32'h300;
        tick();
        tick();
        check("wait_busy", busywait, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_wait_busy", busywait, 1'b0);
        check("rst_wait_req", mem_req, 1'b0);
        mem_rdata = 32'h0BAD0BAD;
        mem_ack   = 1'b1;
        tick();
        mem_ack    = 1'b0;
        read_write = RW_NONE;
        reset_n    = 1'b1;
        #1;
        check("rst_wait_load", load_data, 32'h0);
        check("post_rst_req", mem_req, 1'b0);
        tick();
        check("post_rst_idle_req", mem_req, 1'b0);
        check("post_rst_idle_busy", busywait, 1'b0);

        run_op(RW_LW, 32'h102, 32'h0, 32'h0BADF00D, -1);
`ifdef MISALIGN_TRAP_EN
        check("mis_busy_cycles", busy_n, 1);
        check("mis_no_req", snap_req, 1'b0);
        check("mis_flt_done", misalign_flt, 1'b1);
        check("mis_load_unchanged", load_data, 32'h0);
        tick();
        read_write = RW_NONE;
        #1;
        check("mis_flt_cleared", misalign_flt, 1'b0);
`else
        check("mis_trunc_busy", busy_n, 20);
        check("mis_trunc_addr", snap_addr, 32'h40);
        check("mis_trunc_be", snap_be, 4'hF);
        check("mis_trunc_req", snap_req, 1'b1);
        check("mis_flt_tied", misalign_flt, 1'b0);
        mem_ack = 1'b1;
        #1;
        tick();
        mem_ack = 1'b0;
        #1;
        check("mis_trunc_load", load_data, 32'h0BADF00D);
        check("mis_trunc_done_busy", busywait, 1'b0);
        tick();
        read_write = RW_NONE;
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
